bridge_req_mux: RTL and testbench

- Parametrised N-channel arbiter for core-originated (target) bridge commands such as ready_to_run, dataslot_read/write/flush and open_dataslot_file.
- Round-robin selects one pending channel request and issues it on a single host-facing request port.
- Waits for the host response, then routes status and data back to the originating channel.
- Sits between the per-command core_* interface adapters and the bridge driver's req side; replaces the fixed one-request-at-a-time wiring.

---
 rtl/bridge_req_mux.sv | 187 ++++++++++++++++++
 tb/tb_bridge_req_mux.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bridge_req_mux.sv
// bridge_req_mux: round-robin arbiter that funnels NUM_CH core-side bridge
// commands onto one host request port and routes each host response back to
// the channel that issued it. Only one command is outstanding at a time.
// Optional feature: define BRIDGE_REQ_MUX_TIMEOUT_EN to add a WAIT-state
// timeout that synthesises a status 8'hFF response and discards the late reply.
module bridge_req_mux #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned PARAM_W        = 128,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_CH-1:0]           ch_req_valid,
  output logic [NUM_CH-1:0]           ch_req_ready,
  input  logic [NUM_CH*16-1:0]        ch_req_cmd,
  input  logic [NUM_CH*PARAM_W-1:0]   ch_req_param,
  output logic [NUM_CH-1:0]           ch_resp_valid,
  output logic [7:0]                  ch_resp_status,
  output logic [31:0]                 ch_resp_data,
  output logic                        host_req_valid,
  input  logic                        host_req_ready,
  output logic [15:0]                 host_req_cmd,
  output logic [PARAM_W-1:0]          host_req_param,
  input  logic                        host_resp_valid,
  input  logic [7:0]                  host_resp_status,
  input  logic [31:0]                 host_resp_data,
  output logic                        busy,
  output logic [$clog2(NUM_CH)-1:0]   grant_id,
  output logic                        timeout_pulse
);

  localparam int unsigned ID_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [15:0]         cmd_q, cmd_d;
  logic [PARAM_W-1:0]  param_q, param_d;
  logic [7:0]          status_q, status_d;
  logic [31:0]         data_q, data_d;
  logic [NUM_CH-1:0]   resp_vld_q, resp_vld_d;
  logic                host_vld_q, host_vld_d;
  logic                busy_q, busy_d;
  logic                stale_q, stale_d;
  logic                win_found;
  logic [ID_W-1:0]     win_idx;
  logic                resp_ok;
`ifdef BRIDGE_REQ_MUX_TIMEOUT_EN
  logic [31:0]         cnt_q, cnt_d;
  logic                tmo_q, tmo_d;
`else
  logic                unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

  // Round-robin search starting just after the last granted channel
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      if (!win_found && ch_req_valid[ID_W'((32'(rr_ptr_q) + i) % NUM_CH)]) begin
        win_found = 1'b1;
        win_idx   = ID_W'((32'(rr_ptr_q) + i) % NUM_CH);
      end
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    cmd_d        = cmd_q;
    param_d      = param_q;
    status_d     = status_q;
    data_d       = data_q;
    stale_d      = stale_q;
    ch_req_ready = '0;
`ifdef BRIDGE_REQ_MUX_TIMEOUT_EN
    cnt_d        = cnt_q;
    tmo_d        = 1'b0;
`endif

    // A reply owed to a timed-out command is swallowed wherever it lands
    resp_ok = host_resp_valid && !stale_q;
    if (host_resp_valid && stale_q) stale_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_found && reset_n) begin
          ch_req_ready = NUM_CH'(1) << win_idx;
          cmd_d        = ch_req_cmd[32'(win_idx)*16 +: 16];
          param_d      = ch_req_param[32'(win_idx)*PARAM_W +: PARAM_W];
          grant_d      = win_idx;
          rr_ptr_d     = win_idx;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (host_req_ready) begin
          state_d = S_WAIT;
`ifdef BRIDGE_REQ_MUX_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT: begin
        if (resp_ok) begin
          status_d = host_resp_status;
          data_d   = host_resp_data;
          state_d  = S_RESP;
        end
`ifdef BRIDGE_REQ_MUX_TIMEOUT_EN
        else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          status_d = 8'hFF;
          data_d   = 32'h0;
          tmo_d    = 1'b1;
          stale_d  = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    host_vld_d = (state_d == S_ISSUE);
    busy_d     = (state_d != S_IDLE);
    resp_vld_d = (state_d == S_RESP) ? (NUM_CH'(1) << grant_d) : '0;
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= ID_W'(NUM_CH - 1);
      grant_q    <= '0;
      cmd_q      <= '0;
      param_q    <= '0;
      status_q   <= '0;
      data_q     <= '0;
      resp_vld_q <= '0;
      host_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      stale_q    <= 1'b0;
`ifdef BRIDGE_REQ_MUX_TIMEOUT_EN
      cnt_q      <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      cmd_q      <= cmd_d;
      param_q    <= param_d;
      status_q   <= status_d;
      data_q     <= data_d;
      resp_vld_q <= resp_vld_d;
      host_vld_q <= host_vld_d;
      busy_q     <= busy_d;
      stale_q    <= stale_d;
`ifdef BRIDGE_REQ_MUX_TIMEOUT_EN
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign ch_resp_valid  = resp_vld_q;
  assign ch_resp_status = status_q;
  assign ch_resp_data   = data_q;
  assign host_req_valid = host_vld_q;
  assign host_req_cmd   = cmd_q;
  assign host_req_param = param_q;
  assign busy           = busy_q;
  assign grant_id       = grant_q;
`ifdef BRIDGE_REQ_MUX_TIMEOUT_EN
  assign timeout_pulse  = tmo_q;
`else
  assign timeout_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_bridge_req_mux.sv
// Bench for bridge_req_mux: directed scenarios plus randomized transactions
// checked against a transaction-level round-robin model.
module tb_bridge_req_mux;

  localparam int NCH = 4;
  localparam int PW  = 128;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NCH-1:0]  ch_req_valid;
  logic [NCH-1:0]  ch_req_ready;
  logic [NCH*16-1:0] ch_req_cmd;
  logic [NCH*PW-1:0] ch_req_param;
  logic [NCH-1:0]  ch_resp_valid;
  logic [7:0]      ch_resp_status;
  logic [31:0]     ch_resp_data;
  logic            host_req_valid;
  logic            host_req_ready;
  logic [15:0]     host_req_cmd;
  logic [PW-1:0]   host_req_param;
  logic            host_resp_valid;
  logic [7:0]      host_resp_status;
  logic [31:0]     host_resp_data;
  logic            busy;
  logic [1:0]      grant_id;
  logic            timeout_pulse;

  bridge_req_mux #(.NUM_CH(NCH), .PARAM_W(PW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready),
    .ch_req_cmd(ch_req_cmd), .ch_req_param(ch_req_param),
    .ch_resp_valid(ch_resp_valid), .ch_resp_status(ch_resp_status),
    .ch_resp_data(ch_resp_data),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_req_cmd(host_req_cmd), .host_req_param(host_req_param),
    .host_resp_valid(host_resp_valid), .host_resp_status(host_resp_status),
    .host_resp_data(host_resp_data),
    .busy(busy), .grant_id(grant_id), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int last_g = NCH - 1;
  logic [15:0] cmd_a [NCH];
  logic [PW-1:0] par_a [NCH];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: first requester after the last grant, wrapping around
  function automatic int pick(input logic [NCH-1:0] m);
    for (int i = 1; i <= NCH; i++)
      if (m[(last_g + i) % NCH]) return (last_g + i) % NCH;
    return -1;
  endfunction

  task automatic rand_cmds();
    for (int i = 0; i < NCH; i++) begin
      cmd_a[i] = 16'($urandom);
      par_a[i] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One full transaction, entered and left at a negedge with the DUT idle.
  // resp_dly < 0 means the host never answers (timeout expected).
  task automatic txn(input logic [NCH-1:0] mask, input int rdy_dly, input int resp_dly,
                     input logic [7:0] st, input logic [31:0] dt, input bit early);
    int w;
    int n;
    logic [NCH-1:0] oh;
    w = pick(mask);
    last_g = w;
    oh = NCH'(1) << w;
    for (int i = 0; i < NCH; i++) begin
      ch_req_cmd[16*i +: 16]   = cmd_a[i];
      ch_req_param[PW*i +: PW] = par_a[i];
    end
    ch_req_valid = mask;
    if (early) begin
      host_resp_valid  = 1'b1;
      host_resp_status = 8'hEE;
      host_resp_data   = 32'hDEAD_0001;
    end
    #1 chk("req_ready_idle", ch_req_ready, oh);
    step();
    chk("host_valid_issue", host_req_valid, 1'b1);
    chk("host_cmd", host_req_cmd, cmd_a[w]);
    chk("host_param", host_req_param, par_a[w]);
    chk("grant_id", grant_id, w);
    chk("busy_issue", busy, 1'b1);
    ch_req_valid = mask & ~oh;
    #1 chk("req_ready_issue", ch_req_ready, '0);
    for (int k = 0; k < rdy_dly; k++) begin
      step();
      if (early && k == 0) host_resp_valid = 1'b0;
      chk("host_valid_hold", host_req_valid, 1'b1);
      chk("host_cmd_hold", host_req_cmd, cmd_a[w]);
      chk("host_param_hold", host_req_param, par_a[w]);
      #1 chk("req_ready_hold", ch_req_ready, '0);
    end
    host_req_ready = 1'b1;
    step();
    host_req_ready = 1'b0;
    chk("host_valid_drop", host_req_valid, 1'b0);
    chk("busy_wait", busy, 1'b1);
    #1 chk("req_ready_wait", ch_req_ready, '0);
    if (resp_dly >= 0) begin
      for (int k = 0; k < resp_dly; k++) begin
        step();
        chk("no_resp_wait", ch_resp_valid, '0);
      end
      host_resp_valid  = 1'b1;
      host_resp_status = st;
      host_resp_data   = dt;
      step();
      host_resp_valid = 1'b0;
      chk("resp_valid", ch_resp_valid, oh);
      chk("resp_status", ch_resp_status, st);
      chk("resp_data", ch_resp_data, dt);
      chk("no_timeout", timeout_pulse, 1'b0);
    end else begin
      n = 0;
      while (ch_resp_valid == '0 && n < 40) begin
        step();
        n++;
      end
      chk("timeout_latency", n, 16);
      chk("tmo_resp_valid", ch_resp_valid, oh);
      chk("tmo_status", ch_resp_status, 8'hFF);
      chk("tmo_data", ch_resp_data, 32'h0);
      chk("tmo_pulse", timeout_pulse, 1'b1);
    end
    ch_req_valid = '0;
    step();
    chk("busy_back_idle", busy, 1'b0);
    chk("resp_one_cycle", ch_resp_valid, '0);
  endtask

  initial begin
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    reset_n = 1'b0;
    ch_req_valid = '1;
    ch_req_cmd = '0;
    ch_req_param = '0;
    host_req_ready = 1'b0;
    host_resp_valid = 1'b0;
    host_resp_status = '0;
    host_resp_data = '0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", ch_req_ready, '0);
    chk("rst_host_valid", host_req_valid, 1'b0);
    chk("rst_resp_valid", ch_resp_valid, '0);
    chk("rst_grant", grant_id, 2'd0);
    chk("rst_cmd", host_req_cmd, 16'h0);
    ch_req_valid = '0;
    step();
    step();
    reset_n = 1'b1;

    // All channels continuously requesting: strict rotation from channel 0
    for (int k = 0; k < 5; k++) begin
      rand_cmds();
      txn(4'hF, $urandom_range(0, 2), $urandom_range(0, 2), 8'($urandom), $urandom, 1'b0);
      chk("rr_order", grant_id, exp_order[k]);
    end

    // Single request on channel 2
    rand_cmds();
    cmd_a[2] = 16'h0080;
    par_a[2] = 128'h1;
    txn(4'b0100, 0, 0, 8'h00, 32'h1234, 1'b0);

    // Host stalls acceptance for 50 cycles
    rand_cmds();
    txn(4'hF, 50, 1, 8'h11, 32'hCAFE_F00D, 1'b0);

    // Responses in IDLE and ISSUE are ignored
    rand_cmds();
    txn(4'b1010, 2, 3, 8'h02, 32'h0BAD_BEEF, 1'b1);

    // Randomized traffic
    for (int k = 0; k < 20; k++) begin
      rand_cmds();
      txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 4),
          8'($urandom_range(0, 254)), $urandom, 1'b0);
    end

`ifdef BRIDGE_REQ_MUX_TIMEOUT_EN
    rand_cmds();
    txn(4'b0001, 0, -1, 8'h00, 32'h0, 1'b0);
    host_resp_valid  = 1'b1;
    host_resp_status = 8'h55;
    host_resp_data   = 32'h5555_5555;
    step();
    host_resp_valid = 1'b0;
    chk("late_resp_discard", ch_resp_valid, '0);
    chk("late_resp_busy", busy, 1'b0);
    rand_cmds();
    txn(4'b0100, 1, 2, 8'h03, 32'h0000_ABCD, 1'b0);
`endif

    // Reset asserted while waiting for the host
    rand_cmds();
    for (int i = 0; i < NCH; i++) ch_req_cmd[16*i +: 16] = cmd_a[i];
    ch_req_valid = 4'hF;
    step();
    host_req_ready = 1'b1;
    step();
    host_req_ready = 1'b0;
    chk("pre_reset_busy", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_host_valid", host_req_valid, 1'b0);
    chk("arst_req_ready", ch_req_ready, '0);
    chk("arst_resp_valid", ch_resp_valid, '0);
    chk("arst_grant", grant_id, 2'd0);
    chk("arst_cmd", host_req_cmd, 16'h0);
    chk("arst_status", ch_resp_status, 8'h0);
    ch_req_valid = '0;
    step();
    reset_n = 1'b1;
    last_g = NCH - 1;
    rand_cmds();
    txn(4'hF, 1, 1, 8'h44, 32'h7777_0000, 1'b0);
    chk("post_reset_grant", grant_id, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
